iq_flow_ctrl: RTL and testbench
===============================

// Module: iq_flow_ctrl
// PURPOSE
//  Flow controller that sequences the 16-entry issue queue.
//  - Decides each cycle how many dispatched uops are written (0-4) and how many oldest entries are issued (0-2).
//  - Keeps the authoritative occupancy count and back-pressures dispatch.
//  - Steers the two queue output slots onto two execution pipes.
//  - Sequences pipeline flush.
// PARAMETERS
//  IQ_DEPTH     16  issue queue entries; power of two, >= 8
//  DISP_WIDTH   4   max uops offered by dispatch per cycle
//  ISSUE_WIDTH  2   execution pipes / queue read slots
// PORTS
//  clk             in   1  clock, rising edge
//  rst             in   1  asynchronous reset, active-high
//  flush           in   1  pipeline flush request (level)
//  disp_num        in   3  uops offered by dispatch this cycle (0..4; 5-7 illegal)
//  disp_ready      out  1  whole dispatch group accepted this cycle
//  iq_in_num       out  3  write count to issue queue (its in_data_number)
//  pipe_ready      in   2  execution pipe i can take a uop this cycle
//  iq_out_num      out  2  pop count to issue queue (its out_data_number)
//  issue_valid     out  2  pipe i receives a uop this cycle
//  issue_slot_sel  out  2  bit i: queue out slot (0/1) routed to pipe i
//  iq_clear        out  1  one-cycle pulse: queue resets its pointers
//  occupancy       out  5  registered entry count, 0..16
//  free_slots      out  5  IQ_DEPTH - occupancy
// BEHAVIOUR
//  FSM states (registered):
//  - INIT: first cycle after rst release; no write, no pop; -> RUN.
//  - RUN: normal operation; flush=1 -> FLUSH.
//  - FLUSH: iq_clear=1 on the entry cycle only; occupancy forced to 0.
//    disp_ready=0, in/out counts 0, issue_valid=0 while in FLUSH.
//    Leaves to RUN on the first cycle flush=0.
//  Dispatch (RUN only, combinational from registered occupancy, 0-cycle latency):
//  - All-or-nothing: disp_ready = (disp_num <= free_slots).
//  - iq_in_num = disp_ready ? disp_num : 0.
//  - Same-cycle pops are NOT credited: a full queue never accepts even while issuing.
//  - disp_num=0 -> disp_ready=1, iq_in_num=0.
//  - disp_num>4 -> treated as 0 (assertion fires in sim).
//  Issue (RUN only):
//  - k = popcount(pipe_ready); iq_out_num = min(k, occupancy).
//  - Slot0 (oldest) goes to the lowest-index ready pipe; slot1 to the other ready pipe.
//  - Only pipe1 ready, occupancy>=1 -> issue_valid=2'b10, issue_slot_sel[1]=0.
//  - Both ready, occupancy=1 -> issue_valid=2'b01, slot0 -> pipe0.
//  - issue_slot_sel bits for invalid pipes are 0.
//  Occupancy:
//  - occupancy <= occupancy + iq_in_num - iq_out_num at each edge in RUN.
//  - 5-bit unsigned arithmetic; never exceeds IQ_DEPTH and never underflows (by construction, asserted).
//  - Write and pop in the same cycle are legal, including occupancy=16 with 2 pops (in=0).
//  Reset (async, any time, including mid-FLUSH):
//  - state=INIT, occupancy=0, free_slots=16, disp_ready=0, iq_clear=0.
//  - All count and valid outputs are 0.
//  - flush asserted during INIT -> FLUSH next cycle (INIT->RUN->FLUSH is not taken).
// CONFIGURATION
//  Macro IQ_FLOW_PERF_EN.
//  - Defined: adds outputs perf_full_stall[31:0] (cycles with disp_num!=0 && !disp_ready in RUN)
//    and perf_empty[31:0] (RUN cycles with occupancy=0 and pipe_ready!=0).
//    Both counters are saturating, cleared by rst, not by flush.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - defines.svh: IQ_ADDR, IQ_DEPTH constant, IQ_CNT (5-bit occupancy type),
//    enum IQ_FLOW_STATE {INIT,RUN,FLUSH}.
//  - One sub-module, iq_issue_steer: pure combinational ready-mask + occupancy ->
//    iq_out_num, issue_valid, issue_slot_sel.
//  - FSM, occupancy and perf counters stay in iq_flow_ctrl.
// TESTING
//  1. Reset release, disp_num=4 each cycle, pipe_ready=0:
//     INIT cycle in=0; then in=4 x4, occupancy 16; next cycle disp_ready=0, in=0.
//  2. Occupancy=15, disp_num=2, pipe_ready=2'b11:
//     disp_ready=0, out=2, occupancy -> 13.
//  3. Occupancy=1, pipe_ready=2'b10:
//     out=1, issue_valid=10, slot_sel[1]=0, occupancy -> 0; next cycle out=0.
//  4. Occupancy=9, flush held 3 cycles:
//     iq_clear one pulse on first FLUSH cycle, occupancy=0, disp_ready=0 throughout; RUN after flush drops.
//  5. Async rst asserted mid-FLUSH with occupancy=7:
//     outputs zero immediately, occupancy=0, INIT after release.
//  6. IQ_FLOW_PERF_EN, full queue, disp_num=3 for 5 cycles:
//     perf_full_stall=5; flush leaves it unchanged; rst clears it.

Source files
------------

// File: rtl/iq_flow_ctrl_pkg.sv
// Shared types and constants for the issue-queue flow controller.
package iq_flow_ctrl_pkg;

    localparam int unsigned IqDepth    = 16;
    localparam int unsigned IqAddr     = $clog2(IqDepth);
    localparam int unsigned DispWidth  = 4;
    localparam int unsigned IssueWidth = 2;

    // One extra bit so a completely full queue (IqDepth entries) is representable.
    typedef logic [IqAddr:0] iq_cnt_t;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StFlush
    } iq_flow_state_e;

    function automatic iq_cnt_t free_of(iq_cnt_t occ);
        return iq_cnt_t'(IqDepth) - occ;
    endfunction

endpackage

// File: rtl/iq_flow_ctrl_if.sv
// Dispatch/issue handshake bundle between the flow controller and its surroundings.
// Perf counter signals exist only when IQ_FLOW_PERF_EN is defined.
interface iq_flow_ctrl_if;
    import iq_flow_ctrl_pkg::*;

    logic                    flush;
    logic [2:0]              disp_num;
    logic                    disp_ready;
    logic [2:0]              iq_in_num;
    logic [IssueWidth-1:0]   pipe_ready;
    logic [1:0]              iq_out_num;
    logic [IssueWidth-1:0]   issue_valid;
    logic [IssueWidth-1:0]   issue_slot_sel;
    logic                    iq_clear;
    iq_cnt_t                 occupancy;
    iq_cnt_t                 free_slots;
`ifdef IQ_FLOW_PERF_EN
    logic [31:0]             perf_full_stall;
    logic [31:0]             perf_empty;
`endif

    modport slave (
        input  flush, disp_num, pipe_ready,
        output disp_ready, iq_in_num, iq_out_num, issue_valid, issue_slot_sel,
        output iq_clear, occupancy, free_slots
`ifdef IQ_FLOW_PERF_EN
        , output perf_full_stall, perf_empty
`endif
    );

    modport master (
        output flush, disp_num, pipe_ready,
        input  disp_ready, iq_in_num, iq_out_num, issue_valid, issue_slot_sel,
        input  iq_clear, occupancy, free_slots
`ifdef IQ_FLOW_PERF_EN
        , input perf_full_stall, perf_empty
`endif
    );

endinterface

// File: rtl/iq_flow_ctrl_issue_steer.sv
// Combinational steering of the two oldest queue slots onto ready execution pipes.
module iq_issue_steer
    import iq_flow_ctrl_pkg::*;
(
    input  logic       en_i,
    input  logic [1:0] ready_i,
    input  iq_cnt_t    occ_i,
    output logic [1:0] out_num_o,
    output logic [1:0] valid_o,
    output logic [1:0] slot_sel_o
);

    always_comb begin
        valid_o    = 2'b00;
        slot_sel_o = 2'b00;
        if (en_i && (occ_i != '0)) begin
            case (ready_i)
                2'b01: valid_o = 2'b01;
                2'b10: valid_o = 2'b10;
                2'b11: begin
                    // Slot0 always lands on pipe0; slot1 only exists with two entries.
                    if (occ_i >= iq_cnt_t'(2)) begin
                        valid_o    = 2'b11;
                        slot_sel_o = 2'b10;
                    end else begin
                        valid_o    = 2'b01;
                    end
                end
                default: valid_o = 2'b00;
            endcase
        end
        out_num_o = {1'b0, valid_o[0]} + {1'b0, valid_o[1]};
    end

endmodule

// File: rtl/iq_flow_ctrl.sv
// Issue-queue flow controller: FSM, dispatch back-pressure, occupancy and issue steering.
// Optional saturating perf counters when IQ_FLOW_PERF_EN is defined.
module iq_flow_ctrl
    import iq_flow_ctrl_pkg::*;
(
    input logic           clk,
    input logic           rst,
    iq_flow_ctrl_if.slave bus
);

    iq_flow_state_e state_q, state_d;
    iq_cnt_t        occ_q, occ_d;
    logic           clear_q, clear_d;

    logic       run;
    logic [2:0] disp_eff;
    logic [2:0] disp_num;
    iq_cnt_t    free;
    logic       disp_ready;
    logic [2:0] in_num;
    logic [1:0] out_num;

    assign disp_num = bus.disp_num;

    iq_issue_steer u_steer (
        .en_i       (run),
        .ready_i    (bus.pipe_ready),
        .occ_i      (occ_q),
        .out_num_o  (out_num),
        .valid_o    (bus.issue_valid),
        .slot_sel_o (bus.issue_slot_sel)
    );

    always_comb begin
        run        = (state_q == StRun);
        disp_eff   = (disp_num <= 3'd4) ? disp_num : 3'd0;
        free       = free_of(occ_q);
        // Pops in this cycle are deliberately not credited to free space.
        disp_ready = run && (iq_cnt_t'(disp_eff) <= free);
        in_num     = disp_ready ? disp_eff : 3'd0;

        state_d = state_q;
        case (state_q)
            StInit:  state_d = bus.flush ? StFlush : StRun;
            StRun:   if (bus.flush) state_d = StFlush;
            StFlush: if (!bus.flush) state_d = StRun;
            default: state_d = StInit;
        endcase

        occ_d = occ_q;
        if (run) occ_d = occ_q + iq_cnt_t'(in_num) - iq_cnt_t'(out_num);
        if (state_d == StFlush) occ_d = '0;

        clear_d = (state_d == StFlush) && (state_q != StFlush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            occ_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            clear_q <= clear_d;
        end
    end

    assign bus.disp_ready = disp_ready;
    assign bus.iq_in_num  = in_num;
    assign bus.iq_out_num = out_num;
    assign bus.iq_clear   = clear_q;
    assign bus.occupancy  = occ_q;
    assign bus.free_slots = free;

`ifdef IQ_FLOW_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] empty_q, empty_d;

    always_comb begin
        stall_d = stall_q;
        empty_d = empty_q;
        if (run && (disp_eff != 3'd0) && !disp_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
        if (run && (occ_q == '0) && (bus.pipe_ready != '0) && (empty_q != '1)) begin
            empty_d = empty_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            empty_q <= '0;
        end else begin
            stall_q <= stall_d;
            empty_q <= empty_d;
        end
    end

    assign bus.perf_full_stall = stall_q;
    assign bus.perf_empty      = empty_q;
`endif

    a_disp_num_legal: assert property (@(posedge clk) disable iff (rst) disp_num <= 3'd4);
    a_occ_bound:      assert property (@(posedge clk) disable iff (rst)
                                       occ_q <= iq_cnt_t'(IqDepth));

endmodule

// File: tb/tb_iq_flow_ctrl.sv
// Directed self-checking bench for iq_flow_ctrl.
module tb_iq_flow_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    iq_flow_ctrl_if bus ();

    iq_flow_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int unsigned dn, input int unsigned pr, input logic fl);
        bus.disp_num   = 3'(dn);
        bus.pipe_ready = 2'(pr);
        bus.flush      = fl;
        #1;
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.disp_num   = 3'd4;
        bus.pipe_ready = 2'b00;
        #23;
        check("rst_occ",   bus.occupancy, 0);
        check("rst_free",  bus.free_slots, 16);
        check("rst_ready", bus.disp_ready, 0);
        check("rst_clear", bus.iq_clear, 0);

        // 1: fill from reset with disp_num=4
        rst = 1'b0;
        drive(4, 0, 0);
        check("init_in", bus.iq_in_num, 0);
        check("init_ready", bus.disp_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            drive(4, 0, 0);
            check("fill_in", bus.iq_in_num, 4);
            check("fill_occ", bus.occupancy, 4 * i);
        end
        tick();
        drive(4, 0, 0);
        check("full_occ", bus.occupancy, 16);
        check("full_free", bus.free_slots, 0);
        check("full_ready", bus.disp_ready, 0);
        check("full_in", bus.iq_in_num, 0);

        // 2: full queue issuing does not accept; then 15 -> 13
        drive(0, 1, 0);
        check("pop1_out", bus.iq_out_num, 1);
        tick();
        drive(2, 3, 0);
        check("occ15", bus.occupancy, 15);
        check("t2_ready", bus.disp_ready, 0);
        check("t2_out", bus.iq_out_num, 2);
        check("t2_valid", bus.issue_valid, 3);
        check("t2_sel", bus.issue_slot_sel, 2);
        tick();
        check("t2_occ", bus.occupancy, 13);

        // 3: drain to 1, then single-entry cases
        for (int i = 0; i < 6; i++) begin
            drive(0, 3, 0);
            tick();
        end
        drive(0, 3, 0);
        check("occ1", bus.occupancy, 1);
        check("both_occ1_valid", bus.issue_valid, 1);
        check("both_occ1_sel", bus.issue_slot_sel, 0);
        drive(0, 2, 0);
        check("p1_out", bus.iq_out_num, 1);
        check("p1_valid", bus.issue_valid, 2);
        check("p1_sel", bus.issue_slot_sel, 0);
        tick();
        drive(0, 3, 0);
        check("empty_occ", bus.occupancy, 0);
        check("empty_out", bus.iq_out_num, 0);
        check("empty_valid", bus.issue_valid, 0);

        // 4: occupancy 9, flush held
        drive(4, 0, 0); tick();
        drive(4, 0, 0); tick();
        drive(1, 0, 0); tick();
        drive(2, 3, 1);
        check("pre_flush_occ", bus.occupancy, 9);
        tick();
        drive(2, 3, 1);
        check("fl1_clear", bus.iq_clear, 1);
        check("fl1_occ", bus.occupancy, 0);
        check("fl1_ready", bus.disp_ready, 0);
        check("fl1_in", bus.iq_in_num, 0);
        check("fl1_valid", bus.issue_valid, 0);
        tick();
        drive(2, 3, 1);
        check("fl2_clear", bus.iq_clear, 0);
        check("fl2_ready", bus.disp_ready, 0);
        tick();
        drive(2, 3, 0);
        check("fl3_ready", bus.disp_ready, 0);
        check("fl3_out", bus.iq_out_num, 0);
        tick();
        drive(2, 0, 0);
        check("post_fl_ready", bus.disp_ready, 1);
        check("post_fl_in", bus.iq_in_num, 2);
        tick();

        // 5: async reset mid-FLUSH with occupancy 7, flush still high through INIT
        drive(4, 0, 0); tick();
        drive(1, 0, 0); tick();
        drive(0, 0, 1);
        check("occ7", bus.occupancy, 7);
        tick();
        drive(3, 0, 1);
        check("t5_clear_before", bus.iq_clear, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_clear", bus.iq_clear, 0);
        check("t5_rst_occ", bus.occupancy, 0);
        check("t5_rst_free", bus.free_slots, 16);
        check("t5_rst_ready", bus.disp_ready, 0);
        tick();
        rst = 1'b0;
        drive(3, 0, 1);
        check("t5_init_in", bus.iq_in_num, 0);
        check("t5_init_clear", bus.iq_clear, 0);
        tick();
        drive(3, 0, 0);
        check("init_flush_clear", bus.iq_clear, 1);
        check("init_flush_ready", bus.disp_ready, 0);
        tick();
        drive(3, 0, 0);
        check("t5_run_ready", bus.disp_ready, 1);
        check("t5_run_in", bus.iq_in_num, 3);

`ifdef IQ_FLOW_PERF_EN
        // 6: stall counter on a full queue
        rst = 1'b1;
        #1;
        rst = 1'b0;
        drive(4, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(4, 0, 0);
        end
        check("perf_fill_occ", bus.occupancy, 16);
        check("perf_fill_stall", bus.perf_full_stall, 0);
        for (int i = 0; i < 5; i++) begin
            drive(3, 0, 0);
            tick();
        end
        drive(0, 0, 1);
        check("perf_stall5", bus.perf_full_stall, 5);
        tick();
        tick();
        drive(0, 0, 0);
        check("perf_after_flush", bus.perf_full_stall, 5);
        rst = 1'b1;
        #1;
        check("perf_rst", bus.perf_full_stall, 0);
        check("perf_empty_rst", bus.perf_empty, 0);
        rst = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
